// File: rtl/tag_fifo_pkg.sv
// Shared defaults and helpers for the FIX tag-word FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tag_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;

  // Occupancy runs 0..2^addr_width inclusive, so it needs one extra bit.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/tag_fifo_sync_if.sv
// Bus bundle between the tag extractor / field decoder and tag_fifo_sync.
// Latency: n/a (wiring only).
// Backpressure: n/a; the full/almost flags carry it.
// master: drives flush/err_clr/write/read requests, observes data and status.
// slave : the FIFO itself.
interface tag_fifo_sync_if
  import tag_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                               flush_i;
  logic                               err_clr_i;
  logic                               wr_en_i;
  logic [DATA_WIDTH-1:0]              data_i;
  logic                               rd_en_i;
  logic [DATA_WIDTH-1:0]              data_o;
  logic                               valid_o;
  logic                               empty_o;
  logic                               full_o;
  logic                               almost_full_o;
  logic                               almost_empty_o;
  logic [level_width(ADDR_WIDTH)-1:0] level_o;
  logic                               overflow_o;
  logic                               underflow_o;

  modport master (
    output flush_i, err_clr_i, wr_en_i, data_i, rd_en_i,
    input  data_o, valid_o, empty_o, full_o, almost_full_o, almost_empty_o,
           level_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, err_clr_i, wr_en_i, data_i, rd_en_i,
    output data_o, valid_o, empty_o, full_o, almost_full_o, almost_empty_o,
           level_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/tag_fifo_mem.sv
// Storage array: one synchronous write port, one combinational read port, no reset.
// Latency: write visible on rdata the cycle after the write edge.
// Backpressure: none; the caller gates we.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module tag_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tag_fifo_sync.sv
// Synchronous FIFO for parsed FIX tag words, all 2^ADDR_WIDTH entries usable.
// Latency: write->readable next edge; FWFT=1 head shown combinationally, FWFT=0 data one cycle after read edge.
// Backpressure: writes when full (without a same-cycle read) and reads when empty are dropped and flagged sticky.
// Ports: clk, rst (async active-low), bus (slave modport: requests in, data/status out).
module tag_fifo_sync
  import tag_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic            clk,
  input  logic            rst,
  tag_fifo_sync_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = level_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]         level;
  logic                  empty;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  overflow;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A same-cycle write never makes an empty FIFO readable, but a
  // same-cycle read does free a slot for a write into a full FIFO.
  assign rd_acc = bus.rd_en_i && !empty;
  assign wr_acc = bus.wr_en_i && (!full || rd_acc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      level <= level + 1'b1;
      else if (rd_acc && !wr_acc) level <= level - 1'b1;
    end
  end

  // Flush drops requests without flagging them; a new error beats a clear
  // in the same cycle because the set is the later assignment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.err_clr_i) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (!bus.flush_i && bus.wr_en_i && !wr_acc) overflow  <= 1'b1;
      if (!bus.flush_i && bus.rd_en_i && !rd_acc) underflow <= 1'b1;
    end
  end

  tag_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !bus.flush_i),
    .waddr (wr_ptr),
    .wdata (bus.data_i),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign bus.level_o        = level;
  assign bus.empty_o        = empty;
  assign bus.full_o         = full;
  assign bus.almost_full_o  = (level >= LW'(AF_THRESH));
  assign bus.almost_empty_o = (level <= LW'(AE_THRESH));
  assign bus.overflow_o     = overflow;
  assign bus.underflow_o    = underflow;

  generate
    if (FWFT != 0) begin : g_fwft
      // Storage has no reset, so mask the head word while nothing is queued.
      assign bus.data_o  = empty ? '0 : mem_rdata;
      assign bus.valid_o = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (bus.flush_i) begin
          valid_q <= 1'b0;
        end else if (rd_acc) begin
          data_q  <= mem_rdata;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end

      assign bus.data_o  = data_q;
      assign bus.valid_o = valid_q;
    end
  endgenerate

endmodule
